// File: rtl/imem_loader_bank_pkg.sv
// imem_loader_bank_pkg
// Purpose : shared definitions for the instruction-memory loader bank:
//           loader/run state encodings, the instruction word width, the
//           default load base address and the parity helper.
// Ports   : none (package).
// Macros  : INS_START_ADDRESS (default byte address of word 0, overridable
//           on the command line); IMEM_PARITY_EN (optional per-word parity).
`ifndef INS_START_ADDRESS
`define INS_START_ADDRESS 32'h0000_1000
`endif

package imem_loader_bank_pkg;

  localparam int WORD_W = 32;

  localparam logic [31:0] INS_START_ADDR_DEFAULT = `INS_START_ADDRESS;

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_FLUSH = 2'd1,
    S_RUN   = 2'd2
  } imem_state_e;

  // Even parity: stored bit makes the total number of ones even.
  function automatic logic even_parity(input logic [WORD_W-1:0] w);
    return ^w;
  endfunction

endpackage

// File: rtl/imem_loader_bank_byte_assembler.sv
// imem_byte_assembler
// Purpose : assembles accepted load bytes into 32-bit words. Tracks the
//           partial word (index, filled-lane count, lane bytes), detects
//           sequential bytes, and produces up to two commits per cycle:
//             commit A - the held partial word, zero-padded, pushed out by a
//                        non-sequential byte, by load_last or by a flush;
//             commit B - the word containing this cycle's byte, when it
//                        reaches four bytes or carries load_last.
// Ports   : i_clk, i_rst_n (async active-low)
//           i_byte_valid/i_byte/i_word_idx/i_lane : in-range accepted byte
//           i_last  : accepted handshake carried load_last
//           i_flush : commit any held partial word now
//           o_commit_a/o_idx_a/o_data_a, o_commit_b/o_idx_b/o_data_b
//           o_partial_next : a partial word remains after this edge
module imem_byte_assembler
  import imem_loader_bank_pkg::*;
#(
  parameter int IDX_W      = 8,
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_byte_valid,
  input  logic [7:0]        i_byte,
  input  logic [IDX_W-1:0]  i_word_idx,
  input  logic [1:0]        i_lane,
  input  logic              i_last,
  input  logic              i_flush,
  output logic              o_commit_a,
  output logic [IDX_W-1:0]  o_idx_a,
  output logic [WORD_W-1:0] o_data_a,
  output logic              o_commit_b,
  output logic [IDX_W-1:0]  o_idx_b,
  output logic [WORD_W-1:0] o_data_b,
  output logic              o_partial_next
);

  logic [2:0]       r_count;   // 0 means no partial word held
  logic [3:0][7:0]  r_asm;     // indexed by byte lane
  logic [IDX_W-1:0] r_idx;

  logic             w_held;
  logic             w_seq;
  logic [3:0][7:0]  w_new_asm;
  logic [2:0]       w_new_count;
  logic [2:0]       w_count_next;
  logic [3:0][7:0]  w_asm_next;
  logic [IDX_W-1:0] w_idx_next;

  // Lane 0 is the lowest byte address.
  function automatic logic [WORD_W-1:0] lanes_to_word(input logic [3:0][7:0] a);
    return BIG_ENDIAN ? {a[0], a[1], a[2], a[3]} : {a[3], a[2], a[1], a[0]};
  endfunction

  assign w_held = (r_count != 3'd0);
  assign w_seq  = w_held && (i_word_idx == r_idx) && ({1'b0, i_lane} == r_count);

  always_comb begin
    // A non-sequential byte starts from an all-zero word, so unfilled lanes
    // are the zero padding.
    w_new_asm         = w_seq ? r_asm : '0;
    w_new_asm[i_lane] = i_byte;
    w_new_count       = w_seq ? (r_count + 3'd1) : ({1'b0, i_lane} + 3'd1);

    o_commit_a = w_held && (i_byte_valid ? !w_seq : (i_last || i_flush));
    o_commit_b = i_byte_valid && ((w_new_count == 3'd4) || i_last);

    w_count_next = r_count;
    w_asm_next   = r_asm;
    w_idx_next   = r_idx;
    if (i_byte_valid) begin
      w_idx_next = i_word_idx;
      if (o_commit_b) begin
        w_count_next = 3'd0;
        w_asm_next   = '0;
      end else begin
        w_count_next = w_new_count;
        w_asm_next   = w_new_asm;
      end
    end else if (o_commit_a) begin
      w_count_next = 3'd0;
      w_asm_next   = '0;
    end
  end

  assign o_idx_a        = r_idx;
  assign o_data_a       = lanes_to_word(r_asm);
  assign o_idx_b        = i_word_idx;
  assign o_data_b       = lanes_to_word(w_new_asm);
  assign o_partial_next = (w_count_next != 3'd0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= 3'd0;
      r_asm   <= '0;
      r_idx   <= '0;
    end else begin
      r_count <= w_count_next;
      r_asm   <= w_asm_next;
      r_idx   <= w_idx_next;
    end
  end

endmodule

// File: rtl/imem_loader_bank.sv
// imem_loader_bank
// Purpose : word-organised instruction memory with a handshaked byte loader,
//           a load/flush/run state machine gating execution, and a
//           combinational fetch port with alignment and range faults.
// Ports   : SYS_clk, SYS_reset_n (async active-low), SYS_start_button
//           load_valid/load_ready/load_data/load_addr/load_last : byte loader
//           PC -> instruction, fetch_fault           : fetch port
//           execution_enable, load_error, words_loaded : status
//           parity_error                              : only with IMEM_PARITY_EN
// Macros  : IMEM_PARITY_EN adds a stored even-parity bit per word and the
//           parity_error output; INS_START_ADDRESS sets the BASE_ADDR default.
module imem_loader_bank
  import imem_loader_bank_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = ADDR_WIDTH'(INS_START_ADDR_DEFAULT),
  parameter int                    DEPTH_WORDS = 256,
  parameter bit                    BIG_ENDIAN  = 1'b1
) (
  input  logic                           SYS_clk,
  input  logic                           SYS_reset_n,
  input  logic                           SYS_start_button,
  input  logic                           load_valid,
  output logic                           load_ready,
  input  logic [7:0]                     load_data,
  input  logic [ADDR_WIDTH-1:0]          load_addr,
  input  logic                           load_last,
  input  logic [ADDR_WIDTH-1:0]          PC,
  output logic [WORD_W-1:0]              instruction,
  output logic                           fetch_fault,
`ifdef IMEM_PARITY_EN
  output logic                           parity_error,
`endif
  output logic                           execution_enable,
  output logic                           load_error,
  output logic [$clog2(DEPTH_WORDS):0]   words_loaded
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int CNT_W = IDX_W + 1;
  localparam logic [CNT_W:0] DEPTH_CAP = (CNT_W+1)'(DEPTH_WORDS);

  imem_state_e r_state, w_state_next;
  logic        r_exec_en;
  logic        r_load_error;
  logic [CNT_W-1:0]       r_words;
  logic [DEPTH_WORDS-1:0] r_valid;
  logic [WORD_W-1:0]      r_mem [DEPTH_WORDS];

  logic                  w_load_ready, w_flush, w_accept, w_in_range;
  logic [ADDR_WIDTH-1:0] w_ld_off, w_pc_off;
  logic [IDX_W-1:0]      w_pc_idx;
  logic                  w_fault;
  logic                  w_commit_a, w_commit_b, w_partial_next;
  logic [IDX_W-1:0]      w_idx_a, w_idx_b;
  logic [WORD_W-1:0]     w_data_a, w_data_b;
  logic [CNT_W:0]        w_words_sum;

  // Load address decode: below BASE wraps to a huge offset, so the upper
  // offset bits catch both ends of the window.
  assign w_ld_off   = load_addr - BASE_ADDR;
  assign w_in_range = (load_addr >= BASE_ADDR) && (w_ld_off[ADDR_WIDTH-1:IDX_W+2] == '0);
  assign w_accept   = load_valid && w_load_ready;

  imem_byte_assembler #(
    .IDX_W      (IDX_W),
    .BIG_ENDIAN (BIG_ENDIAN)
  ) u_asm (
    .i_clk          (SYS_clk),
    .i_rst_n        (SYS_reset_n),
    .i_byte_valid   (w_accept && w_in_range),
    .i_byte         (load_data),
    .i_word_idx     (w_ld_off[IDX_W+1:2]),
    .i_lane         (w_ld_off[1:0]),
    .i_last         (w_accept && load_last),
    .i_flush        (w_flush),
    .o_commit_a     (w_commit_a),
    .o_idx_a        (w_idx_a),
    .o_data_a       (w_data_a),
    .o_commit_b     (w_commit_b),
    .o_idx_b        (w_idx_b),
    .o_data_b       (w_data_b),
    .o_partial_next (w_partial_next)
  );

  // State register
  always_ff @(posedge SYS_clk or negedge SYS_reset_n) begin
    if (!SYS_reset_n) begin
      r_state   <= S_LOAD;
      r_exec_en <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_exec_en <= (w_state_next == S_RUN);
    end
  end

  // Next-state logic; the start decision sees this cycle's byte handling.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_LOAD:  if (SYS_start_button) w_state_next = w_partial_next ? S_FLUSH : S_RUN;
      S_FLUSH: w_state_next = S_RUN;
      S_RUN:   w_state_next = S_RUN;
      default: w_state_next = S_LOAD;
    endcase
  end

  // Output decode
  always_comb begin
    w_load_ready = (r_state == S_LOAD);
    w_flush      = (r_state == S_FLUSH);
  end

  assign load_ready       = w_load_ready;
  assign execution_enable = r_exec_en;
  assign load_error       = r_load_error;
  assign words_loaded     = r_words;

  // Both commits may land in one cycle; words_loaded saturates at DEPTH.
  assign w_words_sum = {1'b0, r_words} + (CNT_W+1)'(w_commit_a) + (CNT_W+1)'(w_commit_b);

  always_ff @(posedge SYS_clk or negedge SYS_reset_n) begin
    if (!SYS_reset_n) begin
      r_load_error <= 1'b0;
      r_words      <= '0;
      r_valid      <= '0;
    end else begin
      if (w_accept && !w_in_range) r_load_error <= 1'b1;
      r_words <= (w_words_sum > DEPTH_CAP) ? DEPTH_CAP[CNT_W-1:0] : w_words_sum[CNT_W-1:0];
      if (w_commit_a) r_valid[w_idx_a] <= 1'b1;
      if (w_commit_b) r_valid[w_idx_b] <= 1'b1;
    end
  end

  // Storage is not reset; the valid bitmap masks stale contents.
  // Commit B is written second so it wins when both target the same word.
  always_ff @(posedge SYS_clk) begin
    if (w_commit_a) r_mem[w_idx_a] <= w_data_a;
    if (w_commit_b) r_mem[w_idx_b] <= w_data_b;
  end

  // Fetch: the offset's low bits only differ from PC[1:0] for an unaligned
  // BASE_ADDR, where a fetch could not land on a stored word anyway.
  assign w_pc_off = PC - BASE_ADDR;
  assign w_pc_idx = w_pc_off[IDX_W+1:2];
  assign w_fault  = (PC[1:0] != 2'b00) || (w_pc_off[1:0] != 2'b00) || (PC < BASE_ADDR) ||
                    (w_pc_off[ADDR_WIDTH-1:IDX_W+2] != '0);

  assign fetch_fault = w_fault;
  assign instruction = (!w_fault && r_valid[w_pc_idx]) ? r_mem[w_pc_idx] : '0;

`ifdef IMEM_PARITY_EN
  logic r_par [DEPTH_WORDS];

  always_ff @(posedge SYS_clk) begin
    if (w_commit_a) r_par[w_idx_a] <= even_parity(w_data_a);
    if (w_commit_b) r_par[w_idx_b] <= even_parity(w_data_b);
  end

  assign parity_error = !w_fault && r_valid[w_pc_idx] &&
                        (even_parity(r_mem[w_pc_idx]) != r_par[w_pc_idx]);
`endif

endmodule

// File: tb/tb_imem_loader_bank.sv
// tb_imem_loader_bank
// Purpose : scoreboard bench for imem_loader_bank. Stimulus pushes expected
//           values into a queue; a monitor on the falling clock edge pops and
//           compares each entry against the DUT outputs.
module tb_imem_loader_bank;

  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam int          DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        load_valid;
  logic        load_ready;
  logic [7:0]  load_data;
  logic [31:0] load_addr;
  logic        load_last;
  logic [31:0] pc;
  logic [31:0] instruction;
  logic        fetch_fault;
  logic        execution_enable;
  logic        load_error;
  logic [8:0]  words_loaded;
`ifdef IMEM_PARITY_EN
  logic        parity_error;
`endif

  imem_loader_bank #(
    .ADDR_WIDTH  (32),
    .BASE_ADDR   (BASE),
    .DEPTH_WORDS (DEPTH),
    .BIG_ENDIAN  (1'b1)
  ) dut (
    .SYS_clk          (clk),
    .SYS_reset_n      (rst_n),
    .SYS_start_button (start),
    .load_valid       (load_valid),
    .load_ready       (load_ready),
    .load_data        (load_data),
    .load_addr        (load_addr),
    .load_last        (load_last),
    .PC               (pc),
    .instruction      (instruction),
    .fetch_fault      (fetch_fault),
`ifdef IMEM_PARITY_EN
    .parity_error     (parity_error),
`endif
    .execution_enable (execution_enable),
    .load_error       (load_error),
    .words_loaded     (words_loaded)
  );

  always #5 clk = ~clk;

  // Signal selectors for scoreboard entries
  localparam int SEL_INSTR = 0, SEL_FAULT = 1, SEL_EXEC = 2,
                 SEL_LERR  = 3, SEL_WORDS = 4, SEL_READY = 5;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic logic [31:0] probe(input int sel);
    case (sel)
      SEL_INSTR: return instruction;
      SEL_FAULT: return {31'd0, fetch_fault};
      SEL_EXEC:  return {31'd0, execution_enable};
      SEL_LERR:  return {31'd0, load_error};
      SEL_WORDS: return {23'd0, words_loaded};
      default:   return {31'd0, load_ready};
    endcase
  endfunction

  // Monitor: compare every pending expectation on the falling edge.
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t        e;
      logic [31:0] act;
      e   = sb.pop_front();
      act = probe(e.sel);
      n_checks++;
      if (act !== e.exp) begin
        n_fail++;
        $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, act, e.exp);
      end else begin
        $display("ok   %s: 0x%08h", e.name, act);
      end
    end
  end

  task automatic expect_val(input string name, input int sel, input logic [31:0] v);
    exp_t e;
    e.name = name;
    e.sel  = sel;
    e.exp  = v;
    sb.push_back(e);
  endtask

  // Let the monitor consume queued expectations.
  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [31:0] a, input logic [7:0] d,
                           input logic last, input logic st);
    load_valid = 1'b1;
    load_addr  = a;
    load_data  = d;
    load_last  = last;
    start      = st;
    tick();
    load_valid = 1'b0;
    load_last  = 1'b0;
    start      = 1'b0;
  endtask

  task automatic fetch_chk(input string name, input logic [31:0] a,
                           input logic [31:0] ins, input logic flt);
    pc = a;
    expect_val({name, "_instr"}, SEL_INSTR, ins);
    expect_val({name, "_fault"}, SEL_FAULT, {31'd0, flt});
    settle();
  endtask

  // Assert reset mid-cycle, check the asynchronous effect, release it
  // away from the clock edge.
  task automatic pulse_reset(input string name);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    expect_val({name, "_exec"},  SEL_EXEC,  32'd0);
    expect_val({name, "_ready"}, SEL_READY, 32'd1);
    expect_val({name, "_words"}, SEL_WORDS, 32'd0);
    expect_val({name, "_lerr"},  SEL_LERR,  32'd0);
    settle();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    load_valid = 1'b0;
    load_data  = 8'h00;
    load_addr  = 32'h0;
    load_last  = 1'b0;
    pc         = BASE;

    // Reset state
    expect_val("rst_exec",  SEL_EXEC,  32'd0);
    expect_val("rst_ready", SEL_READY, 32'd1);
    expect_val("rst_words", SEL_WORDS, 32'd0);
    expect_val("rst_lerr",  SEL_LERR,  32'd0);
    expect_val("rst_instr", SEL_INSTR, 32'd0);
    settle();
    tick();
    rst_n = 1'b1;

    // Full word, big-endian lane order
    send_byte(BASE + 0, 8'h13, 1'b0, 1'b0);
    send_byte(BASE + 1, 8'h00, 1'b0, 1'b0);
    send_byte(BASE + 2, 8'h00, 1'b0, 1'b0);
    expect_val("w0_partial_words", SEL_WORDS, 32'd0);
    settle();
    send_byte(BASE + 3, 8'h00, 1'b0, 1'b0);
    expect_val("w0_words", SEL_WORDS, 32'd1);
    settle();
    fetch_chk("w0", BASE, 32'h1300_0000, 1'b0);

    // Partial word closed by load_last
    send_byte(BASE + 4, 8'hAA, 1'b0, 1'b0);
    send_byte(BASE + 5, 8'hBB, 1'b1, 1'b0);
    expect_val("w1_words", SEL_WORDS, 32'd2);
    settle();
    fetch_chk("w1", BASE + 4, 32'hAABB_0000, 1'b0);

    // Non-sequential byte commits the old partial; load_last on the new
    // byte commits it in the same edge.
    send_byte(BASE + 8, 8'h11, 1'b0, 1'b0);
    expect_val("w2_pending_words", SEL_WORDS, 32'd2);
    settle();
    send_byte(BASE + 16, 8'h22, 1'b1, 1'b0);
    expect_val("w2w4_words", SEL_WORDS, 32'd4);
    settle();
    fetch_chk("w2", BASE + 8,  32'h1100_0000, 1'b0);
    fetch_chk("w4", BASE + 16, 32'h2200_0000, 1'b0);

    // Out-of-range bytes above and below the window
    send_byte(BASE + 4 * DEPTH, 8'h99, 1'b0, 1'b0);
    expect_val("oor_hi_lerr",  SEL_LERR,  32'd1);
    expect_val("oor_hi_words", SEL_WORDS, 32'd4);
    settle();
    send_byte(BASE - 1, 8'h98, 1'b0, 1'b0);
    expect_val("oor_lo_words", SEL_WORDS, 32'd4);
    settle();

    // Fetch faults and unwritten words
    fetch_chk("misalign",  BASE + 2,         32'd0, 1'b1);
    fetch_chk("unwritten", BASE + 12,        32'd0, 1'b0);
    fetch_chk("pc_high",   BASE + 4 * DEPTH, 32'd0, 1'b1);
    fetch_chk("pc_low",    BASE - 4,         32'd0, 1'b1);

    // Byte with start in the same cycle leaves a partial word -> flush
    send_byte(BASE + 12, 8'h55, 1'b0, 1'b1);
    expect_val("flush_exec",  SEL_EXEC,  32'd0);
    expect_val("flush_ready", SEL_READY, 32'd0);
    settle();
    tick();
    expect_val("run_exec",  SEL_EXEC,  32'd1);
    expect_val("run_words", SEL_WORDS, 32'd5);
    expect_val("run_ready", SEL_READY, 32'd0);
    settle();
    fetch_chk("w3", BASE + 12, 32'h5500_0000, 1'b0);

    // Bytes offered in S_RUN are not accepted
    send_byte(BASE + 20, 8'h77, 1'b1, 1'b1);
    expect_val("run_ignore_words", SEL_WORDS, 32'd5);
    settle();

    // Reset while running clears everything
    pulse_reset("rst_run");
    fetch_chk("rst_run_w0", BASE, 32'd0, 1'b0);

    // Clean load, start with no partial word: one edge to execution
    send_byte(BASE + 0, 8'h13, 1'b0, 1'b0);
    send_byte(BASE + 1, 8'h00, 1'b0, 1'b0);
    send_byte(BASE + 2, 8'h00, 1'b0, 1'b0);
    send_byte(BASE + 3, 8'h00, 1'b0, 1'b0);
    start = 1'b1;
    expect_val("start_pre_exec", SEL_EXEC, 32'd0);
    settle();
    tick();
    start = 1'b0;
    expect_val("start_exec",  SEL_EXEC,  32'd1);
    expect_val("start_words", SEL_WORDS, 32'd1);
    settle();
    fetch_chk("start_w0", BASE, 32'h1300_0000, 1'b0);

    // Reset in the middle of a word discards the partial bytes
    pulse_reset("rst_a");
    send_byte(BASE + 32, 8'hA1, 1'b0, 1'b0);
    send_byte(BASE + 33, 8'hA2, 1'b0, 1'b0);
    pulse_reset("rst_mid");
    send_byte(BASE + 34, 8'hCC, 1'b0, 1'b0);
    send_byte(BASE + 35, 8'hDD, 1'b0, 1'b0);
    expect_val("mid_words", SEL_WORDS, 32'd1);
    settle();
    fetch_chk("mid_w8", BASE + 32, 32'h0000_CCDD, 1'b0);
    fetch_chk("mid_w0", BASE,      32'd0,         1'b0);

    settle();
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending entries expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
